// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, FSM states and beat helpers for the serial ALU issue path.
// Imported by the issue controller and its shift-register datapath.
package alu_issue_ctrl_pkg;

  localparam int OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_ADD = 4'd0;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'd1;
  localparam logic [OP_BITS-1:0] OP_AND = 4'd2;
  localparam logic [OP_BITS-1:0] OP_OR  = 4'd3;
  localparam logic [OP_BITS-1:0] OP_XOR = 4'd4;
  localparam logic [OP_BITS-1:0] OP_MOV = 4'd5;
  localparam logic [OP_BITS-1:0] OP_CMP = 4'd6;
  localparam logic [OP_BITS-1:0] OP_ADC = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESULT
  } state_t;

  // Number of serial beats needed to move a word of the given width.
  function automatic int num_beats(input int width, input int nshift);
    return width / nshift;
  endfunction

  // Beat counter width, never below one bit.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_shreg.sv
// Operand serialiser (two PISO shifters) and result deserialiser (SIPO).
// Operands leave LSB beat first; result beats land at the current beat slot.
module alu_issue_ctrl_shreg #(
  parameter int WIDTH  = 16,
  parameter int NSHIFT = 2,
  parameter int BEAT_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WIDTH-1:0]  i_d1,
  input  logic [WIDTH-1:0]  i_d2,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic [NSHIFT-1:0] i_sin,
  output logic [NSHIFT-1:0] o_s1,
  output logic [NSHIFT-1:0] o_s2,
  output logic [WIDTH-1:0]  o_par
);

  localparam int NBEATS = WIDTH / NSHIFT;

  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] r_sh2;
  logic [WIDTH-1:0] r_par;

  // Operand shifters: parallel load on accept, drain one beat per RUN cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else if (i_load) begin
      r_sh1 <= i_d1;
      r_sh2 <= i_d2;
    end else if (i_shift) begin
      r_sh1 <= r_sh1 >> NSHIFT;
      r_sh2 <= r_sh2 >> NSHIFT;
    end
  end

  // Result collector: clear on accept, drop each returned beat in its slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_par <= '0;
    end else if (i_load) begin
      r_par <= '0;
    end else if (i_shift) begin
      for (int b = 0; b < NBEATS; b++) begin
        if (i_beat == BEAT_W'(b)) begin
          r_par[b*NSHIFT +: NSHIFT] <= i_sin;
        end
      end
    end
  end

  assign o_s1  = r_sh1[NSHIFT-1:0];
  assign o_s2  = r_sh2[NSHIFT-1:0];
  assign o_par = r_par;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the serial ALU op interface: accepts a parallel request,
// streams operands to the ALU beat by beat and returns the collected result.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int LOG2_NR  = 3,
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [OP_BITS-1:0]    i_req_op,
  input  logic                  i_req_pair,
  input  logic                  i_req_ext1,
  input  logic                  i_req_ext2,
  input  logic [LOG2_NR-1:0]    i_req_reg1,
  input  logic [LOG2_NR-1:0]    i_req_reg2,
  input  logic                  i_req_update_reg1,
  input  logic [1:0]            i_req_upd_flags,
  input  logic [2*REG_BITS-1:0] i_req_data1,
  input  logic [2*REG_BITS-1:0] i_req_data2,
  output logic                  o_op_valid,
  output logic [OP_BITS-1:0]    o_operation,
  output logic                  o_external_arg1,
  output logic                  o_external_arg2,
  output logic                  o_pair_op,
  output logic                  o_pair_op2,
  output logic [LOG2_NR-1:0]    o_reg1,
  output logic [LOG2_NR-1:0]    o_reg2,
  output logic                  o_update_reg1,
  output logic                  o_update_carry_flags,
  output logic                  o_update_other_flags,
  output logic [NSHIFT-1:0]     o_data_in1,
  output logic [NSHIFT-1:0]     o_data_in2,
  input  logic [NSHIFT-1:0]     i_data_out,
  input  logic                  i_op_done,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [2*REG_BITS-1:0] o_res_data,
  output logic                  o_proto_err
);

  localparam int PAIR_BITS        = 2 * REG_BITS;
  localparam int NUM_BEATS_PAIR   = num_beats(PAIR_BITS, NSHIFT);
  localparam int NUM_BEATS_SINGLE = num_beats(REG_BITS, NSHIFT);
  localparam int BEAT_W           = beat_width(NUM_BEATS_PAIR);

  localparam logic [BEAT_W-1:0] LAST_PAIR   = BEAT_W'(NUM_BEATS_PAIR - 1);
  localparam logic [BEAT_W-1:0] LAST_SINGLE = BEAT_W'(NUM_BEATS_SINGLE - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_run;
  logic w_last;
  logic w_op_valid;
  logic w_res_valid;
  logic w_req_ready;

  logic [BEAT_W-1:0]  r_beat;
  logic               r_proto_err;
  logic [OP_BITS-1:0] r_op;
  logic               r_pair;
  logic               r_ext1;
  logic               r_ext2;
  logic [LOG2_NR-1:0] r_reg1;
  logic [LOG2_NR-1:0] r_reg2;
  logic               r_upd_reg1;
  logic [1:0]         r_upd_flags;

  logic [NSHIFT-1:0] w_s1;
  logic [NSHIFT-1:0] w_s2;

  assign w_last = (r_beat == (r_pair ? LAST_PAIR : LAST_SINGLE));

  // State register; reset returns to IDLE at once, dropping any op in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; RUN ends on op_done or the last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_op_valid  = 1'b0;
    w_res_valid = 1'b0;
    w_req_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = !i_reset;
        w_accept    = i_req_valid && !i_reset;
        if (w_accept) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_op_valid = 1'b1;
        w_run      = 1'b1;
        if (i_op_done || w_last) begin
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        w_res_valid = 1'b1;
        if (i_res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Descriptor latch; held from accept through the whole RUN phase.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op        <= '0;
      r_pair      <= 1'b0;
      r_ext1      <= 1'b0;
      r_ext2      <= 1'b0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_upd_reg1  <= 1'b0;
      r_upd_flags <= 2'b00;
    end else if (w_accept) begin
      r_op        <= i_req_op;
      r_pair      <= i_req_pair;
      r_ext1      <= i_req_ext1;
      r_ext2      <= i_req_ext2;
      r_reg1      <= i_req_reg1;
      r_reg2      <= i_req_reg2;
      r_upd_reg1  <= i_req_update_reg1;
      r_upd_flags <= i_req_upd_flags;
    end
  end

  // Beat counter: restarts on accept, advances once per RUN cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= '0;
    end else if (w_run) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Sticky protocol error when op_done and the beat count disagree.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_proto_err <= 1'b0;
    end else if (w_run && (i_op_done != w_last)) begin
      r_proto_err <= 1'b1;
    end
  end

  alu_issue_ctrl_shreg #(
    .WIDTH  (PAIR_BITS),
    .NSHIFT (NSHIFT),
    .BEAT_W (BEAT_W)
  ) u_shreg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_accept),
    .i_shift (w_run),
    .i_d1    (i_req_data1),
    .i_d2    (i_req_data2),
    .i_beat  (r_beat),
    .i_sin   (i_data_out),
    .o_s1    (w_s1),
    .o_s2    (w_s2),
    .o_par   (o_res_data)
  );

  assign o_req_ready          = w_req_ready;
  assign o_op_valid           = w_op_valid;
  assign o_res_valid          = w_res_valid;
  assign o_proto_err          = r_proto_err;
  assign o_data_in1           = w_op_valid ? w_s1 : '0;
  assign o_data_in2           = w_op_valid ? w_s2 : '0;
  assign o_operation          = r_op;
  assign o_external_arg1      = r_ext1;
  assign o_external_arg2      = r_ext2;
  assign o_pair_op            = r_pair;
  assign o_pair_op2           = r_pair;
  assign o_reg1               = r_reg1;
  assign o_reg2               = r_reg2;
  assign o_update_reg1        = r_upd_reg1;
  assign o_update_carry_flags = r_upd_flags[1];
  assign o_update_other_flags = r_upd_flags[0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a small serial add/sub ALU model.
// Directed vector table plus hand-written multi-cycle corner cases.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_op = '0;
  logic req_pair = 1'b0;
  logic req_ext1 = 1'b0;
  logic req_ext2 = 1'b0;
  logic [2:0] req_reg1 = '0;
  logic [2:0] req_reg2 = '0;
  logic req_update_reg1 = 1'b0;
  logic [1:0] req_upd_flags = '0;
  logic [15:0] req_data1 = '0;
  logic [15:0] req_data2 = '0;
  logic op_valid;
  logic [3:0] operation;
  logic external_arg1, external_arg2;
  logic pair_op, pair_op2;
  logic [2:0] reg1, reg2;
  logic update_reg1, update_carry_flags, update_other_flags;
  logic [1:0] data_in1, data_in2;
  logic [1:0] data_out;
  logic op_done;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [15:0] res_data;
  logic proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_pair(req_pair),
    .i_req_ext1(req_ext1), .i_req_ext2(req_ext2),
    .i_req_reg1(req_reg1), .i_req_reg2(req_reg2),
    .i_req_update_reg1(req_update_reg1),
    .i_req_upd_flags(req_upd_flags),
    .i_req_data1(req_data1), .i_req_data2(req_data2),
    .o_op_valid(op_valid), .o_operation(operation),
    .o_external_arg1(external_arg1),
    .o_external_arg2(external_arg2),
    .o_pair_op(pair_op), .o_pair_op2(pair_op2),
    .o_reg1(reg1), .o_reg2(reg2),
    .o_update_reg1(update_reg1),
    .o_update_carry_flags(update_carry_flags),
    .o_update_other_flags(update_other_flags),
    .o_data_in1(data_in1), .o_data_in2(data_in2),
    .i_data_out(data_out), .i_op_done(op_done),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_proto_err(proto_err)
  );

  // Serial ALU model: 2-bit ripple add/sub with carry kept between beats.
  logic [2:0] alu_cnt;
  logic alu_c;
  logic flag_c;
  logic stub_early = 1'b0;
  logic alu_last;
  logic alu_cin;
  logic [1:0] alu_b;
  logic [2:0] alu_sum;

  always_comb begin
    alu_cin = (alu_cnt == 3'd0) ? (operation == OP_SUB) : alu_c;
    alu_b = (operation == OP_SUB) ? ~data_in2 : data_in2;
    alu_sum = {1'b0, data_in1} + {1'b0, alu_b} + {2'b00, alu_cin};
    data_out = op_valid ? alu_sum[1:0] : 2'b00;
    alu_last = (alu_cnt == (pair_op ? 3'd7 : 3'd3));
    op_done = op_valid && (stub_early ? (alu_cnt == 3'd2) : alu_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_cnt <= '0;
      alu_c <= 1'b0;
      flag_c <= 1'b0;
    end else if (op_valid) begin
      alu_cnt <= alu_cnt + 3'd1;
      alu_c <= alu_sum[2];
      if (alu_last) flag_c <= (operation == OP_SUB) ? ~alu_sum[2] : alu_sum[2];
    end else begin
      alu_cnt <= '0;
    end
  end

  typedef struct {
    string name;
    logic [3:0] op;
    logic pair;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] res;
    logic c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0] op, input logic pair,
                           input logic [15:0] d1, input logic [15:0] d2);
    req_op = op;
    req_pair = pair;
    req_data1 = d1;
    req_data2 = d2;
    req_ext1 = 1'b1;
    req_ext2 = 1'b1;
    req_reg1 = 3'd5;
    req_reg2 = 3'd2;
    req_update_reg1 = 1'b1;
    req_upd_flags = 2'b10;
    req_valid = 1'b1;
  endtask

  // Waits (bounded) for res_valid after an accept edge; k=1 is the cycle after it.
  task automatic wait_res(input logic [3:0] op, input logic pair,
                          output int nv, output int lat, output logic dbad);
    nv = 0;
    lat = -1;
    dbad = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (op_valid) begin
        nv++;
        if (operation !== op || pair_op !== pair || pair_op2 !== pair ||
            reg1 !== 3'd5 || reg2 !== 3'd2 || update_reg1 !== 1'b1 ||
            update_carry_flags !== 1'b1 || update_other_flags !== 1'b0 ||
            external_arg1 !== 1'b1 || external_arg2 !== 1'b1)
          dbad = 1'b1;
      end
      if (res_valid) lat = k;
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic pair,
                       input logic [15:0] d1, input logic [15:0] d2,
                       output int nv, output int lat, output logic dbad);
    @(negedge clk);
    drive_req(op, pair, d1, d2);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_res(op, pair, nv, lat, dbad);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  int nv, lat;
  logic dbad;
  logic [15:0] held;

  initial begin
    vecs[0] = '{"pair_add",  OP_ADD, 1'b1, 16'h1234, 16'h0101, 16'h1335, 1'b0};
    vecs[1] = '{"single_sub", OP_SUB, 1'b0, 16'h0005, 16'h0007, 16'h00FE, 1'b1};
    vecs[2] = '{"pair_wrap", OP_ADD, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[3] = '{"single_wrap", OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1};
    vecs[4] = '{"pair_sub",  OP_SUB, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b0};
    vecs[5] = '{"single_hi", OP_ADD, 1'b0, 16'hAB10, 16'hCD20, 16'h0030, 1'b0};
    vecs[6] = '{"pair_cy8",  OP_ADD, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0};

    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_outs", {op_valid, res_valid, proto_err, res_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].pair, vecs[i].d1, vecs[i].d2, nv, lat, dbad);
      chk({vecs[i].name, "_res"}, {16'd0, res_data}, {16'd0, vecs[i].res});
      chk({vecs[i].name, "_beats"}, nv, vecs[i].pair ? 32'd8 : 32'd4);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].pair ? 32'd9 : 32'd5);
      chk({vecs[i].name, "_flagc"}, {31'd0, flag_c}, {31'd0, vecs[i].c});
      chk({vecs[i].name, "_desc"}, {31'd0, dbad}, 32'd0);
      release_res();
    end
    chk("no_proto_err", {31'd0, proto_err}, 32'd0);

    // Backpressure: result held, nothing else moves.
    do_op(OP_ADD, 1'b1, 16'h4321, 16'h1111, nv, lat, dbad);
    chk("bp_lat", lat, 32'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {13'd0, res_valid, req_ready, op_valid, res_data},
          {13'd0, 3'b100, 16'h5432});
    end
    release_res();

    // Async reset during RUN beat 3.
    @(negedge clk);
    drive_req(OP_ADD, 1'b1, 16'hAAAA, 16'h5555);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("mid_run_valid", {31'd0, op_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_drop", {29'd0, op_valid, res_valid, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_op(OP_ADD, 1'b1, 16'h0002, 16'h0003, nv, lat, dbad);
    chk("after_rst_res", {16'd0, res_data}, 32'h0005);
    chk("after_rst_beats", nv, 32'd8);
    release_res();

    // Early op_done from a misbehaving ALU.
    stub_early = 1'b1;
    do_op(OP_ADD, 1'b1, 16'h1234, 16'h0101, nv, lat, dbad);
    chk("early_beats", nv, 32'd3);
    chk("early_lat", lat, 32'd4);
    chk("early_perr", {31'd0, proto_err}, 32'd1);
    release_res();
    stub_early = 1'b0;
    do_op(OP_ADD, 1'b0, 16'h0001, 16'h0001, nv, lat, dbad);
    chk("sticky_res", {16'd0, res_data}, 32'h0002);
    chk("sticky_perr", {31'd0, proto_err}, 32'd1);
    release_res();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("perr_cleared", {31'd0, proto_err}, 32'd0);

    // Request presented during the result handshake cycle.
    do_op(OP_ADD, 1'b0, 16'h0010, 16'h0020, nv, lat, dbad);
    held = res_data;
    chk("hs_first_res", {16'd0, held}, 32'h0030);
    drive_req(OP_SUB, 1'b0, 16'h0009, 16'h0004);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("hs_idle_cycle", {30'd0, op_valid, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("hs_accepted", {30'd0, op_valid, req_ready}, 32'd2);
    wait_res(OP_SUB, 1'b0, nv, lat, dbad);
    chk("hs_second_res", {16'd0, res_data}, 32'h0005);
    chk("hs_second_beats", nv + 1, 32'd4);
    release_res();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
